// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer: qualifies PLL lock and sequences the
// mining-core reset/enable, with sticky loss-of-lock status.
module pll_lock_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  input  logic       clear_status,
  output logic       core_rst_n,
  output logic       core_en,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  localparam int MAXC =
    (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STB_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST =
    CW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD_RST  = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lost_q, lost_d;
  logic [7:0]             relock_q, relock_d;
  logic                   rstn_q, rstn_d;
  logic                   en_q, en_d;

  assign lk_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_d   = lost_q;
    relock_d = relock_q;
    if (clear_status) lost_d = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = HOLD_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD_RST: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // lock loss outranks a soft reset and a status clear
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else if (soft_reset_req) begin
          state_d = HOLD_RST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    rstn_d = (state_d == RUN);
    en_d   = rstn_q && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      relock_q <= 8'd0;
      rstn_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      relock_q <= relock_d;
      rstn_q   <= rstn_d;
      en_q     <= en_d;
    end
  end

  assign core_rst_n   = rstn_q;
  assign core_en      = en_q;
  assign lock_lost    = lost_q;
  assign relock_count = relock_q;
  assign state        = state_q;

endmodule
